// File: rtl/bin_to_dec_seq_if.sv
// bin_to_dec_seq_if: start/busy/ok handshake and result bus of the binary-to-BCD converter
interface bin_to_dec_seq_if #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
);
  logic                  st;
  logic [BIN_W-1:0]      BIN;
  logic [4*DIGITS-1:0]   DEC;
  logic                  busy;
  logic                  ok;
  logic                  ovf;
  logic [DIGITS-1:0]     blank;
  modport master (output st, BIN, input DEC, busy, ok, ovf, blank);
  modport slave  (input st, BIN, output DEC, busy, ok, ovf, blank);
endinterface

// File: rtl/bin_to_dec_seq.sv
// bin_to_dec_seq: sequential binary-to-BCD by repeated weight subtraction, saturating overflow; leading-zero blanking when BIN2DEC_LZB_EN is defined
module bin_to_dec_seq #(
  parameter int BIN_W  = 12,
  parameter int DIGITS = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  bin_to_dec_seq_if.slave bus
);
  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
  localparam int WW = $clog2(p10(DIGITS) + 1);
  localparam int CW = (BIN_W > WW ? BIN_W : WW) + 1;
  localparam int PW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] LIM = CW'(p10(DIGITS));
  typedef enum logic {IDLE, CONV} state_t;
  state_t              state, state_nx;
  logic [BIN_W-1:0]    rest;
  logic [PW-1:0]       ptr;
  logic [4*DIGITS-1:0] digs;
  logic [CW-1:0]       w_tab [DIGITS];
  logic [CW-1:0]       w;
  logic                ge, acc, ovr, fin;
  for (genvar g = 0; g < DIGITS; g++) begin : g_w
    assign w_tab[g] = CW'(p10(g));
  end
  assign w   = w_tab[ptr];
  assign ge  = CW'(rest) >= w;
  assign acc = state == IDLE && bus.st;
  assign ovr = CW'(bus.BIN) >= LIM;
  assign fin = state == CONV && !ge && ptr == '0;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // next state: overflowing requests never leave IDLE
  always_comb
    state_nx = state == IDLE ? ((acc && !ovr) ? CONV : IDLE) : (fin ? IDLE : CONV);
  // handshake outputs
  always_comb
    bus.busy = state == CONV;
  // datapath: one subtract or digit step per cycle, result latched on completion
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rest    <= '0;
      ptr     <= '0;
      digs    <= '0;
      bus.DEC <= '0;
      bus.ovf <= 1'b0;
      bus.ok  <= 1'b0;
    end else begin
      bus.ok <= (acc && ovr) || fin;
      if (acc && ovr) begin
        bus.DEC <= {DIGITS{4'h9}};
        bus.ovf <= 1'b1;
      end else if (acc) begin
        rest <= bus.BIN;
        ptr  <= PW'(DIGITS - 1);
        digs <= '0;
      end else if (state == CONV) begin
        if (ge) begin
          rest <= rest - BIN_W'(w);
          digs[4*ptr +: 4] <= digs[4*ptr +: 4] + 4'd1;
        end else if (ptr != '0) ptr <= ptr - 1'b1;
        else begin
          bus.DEC <= digs;
          bus.ovf <= 1'b0;
        end
      end
    end
`ifdef BIN2DEC_LZB_EN
  logic [DIGITS-1:0] lzb;
  // digit k is blank when it and every digit above it are zero; digit 0 always shown
  always_comb begin
    lzb = '0;
    for (int k = 1; k < DIGITS; k++) lzb[k] = (digs >> (4 * k)) == '0;
  end
  // blank mask follows each ok; overflow shows all nines unblanked
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) bus.blank <= '0;
    else if (acc && ovr) bus.blank <= '0;
    else if (fin) bus.blank <= lzb;
`else
  assign bus.blank = '0;
`endif
endmodule

// File: tb/tb_bin_to_dec_seq.sv
// tb_bin_to_dec_seq: randomized self-checking bench against an arithmetic decimal model
module tb_bin_to_dec_seq;
`ifdef BIN2DEC_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif
  logic        clk = 1'b0, rst_n = 1'b0, st = 1'b0;
  logic [19:0] bin = '0;
  int          sel = 0, pass = 0, total = 0;
  logic [23:0] dec_s;
  logic        busy_s, ok_s, ovf_s;
  logic [5:0]  blank_s;
  always #5 clk = ~clk;
  bin_to_dec_seq_if #(.BIN_W(12), .DIGITS(4)) if0 ();
  bin_to_dec_seq_if #(.BIN_W(14), .DIGITS(4)) if1 ();
  bin_to_dec_seq_if #(.BIN_W(8),  .DIGITS(6)) if2 ();
  bin_to_dec_seq #(.BIN_W(12), .DIGITS(4)) d0 (.clk(clk), .rst_n(rst_n), .bus(if0));
  bin_to_dec_seq #(.BIN_W(14), .DIGITS(4)) d1 (.clk(clk), .rst_n(rst_n), .bus(if1));
  bin_to_dec_seq #(.BIN_W(8),  .DIGITS(6)) d2 (.clk(clk), .rst_n(rst_n), .bus(if2));
  assign if0.st = st && sel == 0;
  assign if1.st = st && sel == 1;
  assign if2.st = st && sel == 2;
  assign if0.BIN = bin[11:0];
  assign if1.BIN = bin[13:0];
  assign if2.BIN = bin[7:0];
  always_comb begin
    dec_s   = sel == 0 ? 24'(if0.DEC)   : sel == 1 ? 24'(if1.DEC)   : if2.DEC;
    busy_s  = sel == 0 ? if0.busy       : sel == 1 ? if1.busy       : if2.busy;
    ok_s    = sel == 0 ? if0.ok         : sel == 1 ? if1.ok         : if2.ok;
    ovf_s   = sel == 0 ? if0.ovf        : sel == 1 ? if1.ovf        : if2.ovf;
    blank_s = sel == 0 ? 6'(if0.blank)  : sel == 1 ? 6'(if1.blank)  : if2.blank;
  end
  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction
  function automatic int nd(input int s);
    return s == 2 ? 6 : 4;
  endfunction
  function automatic logic [23:0] m_dec(input int v, input int d);
    logic [23:0] r = '0;
    for (int k = 0; k < d; k++) r[4*k +: 4] = v >= p10(d) ? 4'd9 : 4'((v / p10(k)) % 10);
    return r;
  endfunction
  function automatic int m_lat(input int v, input int d);
    int l = d;
    if (v >= p10(d)) return 0;
    for (int k = 0; k < d; k++) l += (v / p10(k)) % 10;
    return l;
  endfunction
  function automatic logic [5:0] m_blank(input int v, input int d);
    logic [5:0] r = '0;
    for (int k = 1; k < d; k++) r[k] = LZB && v < p10(d) && v < p10(k);
    return r;
  endfunction
  task automatic go(input int v, input int mid_n, input int mid_v, output int lat, output int bc);
    @(negedge clk);
    st = 1'b1;
    bin = 20'(v);
    @(posedge clk);
    #1;
    st = 1'b0;
    bin = 20'($urandom);
    lat = 0;
    bc = 0;
    while (!ok_s && lat < 200) begin
      if (busy_s) bc++;
      @(posedge clk);
      #1;
      lat++;
      if (lat == mid_n) begin
        st = 1'b1;
        bin = 20'(mid_v);
      end else st = 1'b0;
    end
    st = 1'b0;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    sel = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (dec_s !== 24'h0) $display("FAIL reset_dec got %h exp 0", dec_s); else pass++;
    total++; if (busy_s !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy_s); else pass++;
    total++; if (ok_s !== 1'b0) $display("FAIL reset_ok got %b exp 0", ok_s); else pass++;
    total++; if (ovf_s !== 1'b0) $display("FAIL reset_ovf got %b exp 0", ovf_s); else pass++;
    total++; if (blank_s !== 6'h0) $display("FAIL reset_blank got %b exp 0", blank_s); else pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_max;
    int lat, bc;
    sel = 0;
    go(4095, 0, 0, lat, bc);
    total++; if (lat !== 22) $display("FAIL max_latency got %0d exp 22", lat); else pass++;
    total++; if (bc !== 22) $display("FAIL max_busy_cycles got %0d exp 22", bc); else pass++;
    total++; if (busy_s !== 1'b0) $display("FAIL max_busy_at_ok got %b exp 0", busy_s); else pass++;
    total++; if (dec_s !== 24'h4095) $display("FAIL max_dec got %h exp 4095", dec_s); else pass++;
    total++; if (ovf_s !== 1'b0) $display("FAIL max_ovf got %b exp 0", ovf_s); else pass++;
    total++; if (blank_s !== m_blank(4095, 4)) $display("FAIL max_blank got %b exp %b", blank_s, m_blank(4095, 4)); else pass++;
  endtask
  task automatic test_zero;
    int lat, bc;
    sel = 0;
    go(0, 0, 0, lat, bc);
    total++; if (lat !== 4) $display("FAIL zero_latency got %0d exp 4", lat); else pass++;
    total++; if (dec_s !== 24'h0) $display("FAIL zero_dec got %h exp 0", dec_s); else pass++;
    total++; if (blank_s !== m_blank(0, 4)) $display("FAIL zero_blank got %b exp %b", blank_s, m_blank(0, 4)); else pass++;
  endtask
  task automatic test_random(input int s, input int n, input int maxv);
    int v, lat, bc, d;
    sel = s;
    d = nd(s);
    for (int i = 0; i < n; i++) begin
      v = int'($urandom_range(maxv, 0));
      go(v, 0, 0, lat, bc);
      total++; if (dec_s !== m_dec(v, d)) $display("FAIL rand%0d_dec v=%0d got %h exp %h", s, v, dec_s, m_dec(v, d)); else pass++;
      total++; if (lat !== m_lat(v, d)) $display("FAIL rand%0d_latency v=%0d got %0d exp %0d", s, v, lat, m_lat(v, d)); else pass++;
      total++; if (ovf_s !== (v >= p10(d))) $display("FAIL rand%0d_ovf v=%0d got %b exp %b", s, v, ovf_s, v >= p10(d)); else pass++;
      total++; if (blank_s !== m_blank(v, d)) $display("FAIL rand%0d_blank v=%0d got %b exp %b", s, v, blank_s, m_blank(v, d)); else pass++;
      total++; if (bc !== m_lat(v, d)) $display("FAIL rand%0d_busy_cycles v=%0d got %0d exp %0d", s, v, bc, m_lat(v, d)); else pass++;
    end
  endtask
  task automatic test_ignore_st;
    int lat, bc;
    sel = 0;
    go(1234, 3, 7, lat, bc);
    total++; if (dec_s !== 24'h1234) $display("FAIL ignore_dec got %h exp 1234", dec_s); else pass++;
    total++; if (lat !== 14) $display("FAIL ignore_latency got %0d exp 14", lat); else pass++;
    go(7, 0, 0, lat, bc);
    total++; if (lat !== 11) $display("FAIL b2b_latency got %0d exp 11", lat); else pass++;
    total++; if (dec_s !== 24'h0007) $display("FAIL b2b_dec got %h exp 0007", dec_s); else pass++;
    total++; if (blank_s !== m_blank(7, 4)) $display("FAIL b2b_blank got %b exp %b", blank_s, m_blank(7, 4)); else pass++;
  endtask
  task automatic test_abort;
    int n = 0, v, lat, bc;
    sel = 0;
    @(negedge clk);
    st = 1'b1;
    bin = 20'd4095;
    @(posedge clk);
    #1;
    st = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    total++; if (busy_s !== 1'b1) $display("FAIL abort_busy_before got %b exp 1", busy_s); else pass++;
    total++; if (dec_s !== 24'h0007) $display("FAIL abort_dec_held got %h exp 0007", dec_s); else pass++;
    rst_n = 1'b0;
    #1;
    total++; if (dec_s !== 24'h0) $display("FAIL abort_dec got %h exp 0", dec_s); else pass++;
    total++; if (busy_s !== 1'b0) $display("FAIL abort_busy got %b exp 0", busy_s); else pass++;
    total++; if ({ok_s, ovf_s, blank_s} !== 8'h0) $display("FAIL abort_flags got %h exp 0", {ok_s, ovf_s, blank_s}); else pass++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (ok_s) n++;
    end
    total++; if (n !== 0) $display("FAIL abort_no_ok got %0d exp 0", n); else pass++;
    v = int'($urandom_range(4095, 0));
    go(v, 0, 0, lat, bc);
    total++; if (dec_s !== m_dec(v, 4)) $display("FAIL abort_after_dec v=%0d got %h exp %h", v, dec_s, m_dec(v, 4)); else pass++;
  endtask
  task automatic test_overflow;
    int lat, bc;
    sel = 1;
    go(10000, 0, 0, lat, bc);
    total++; if (lat !== 0) $display("FAIL ovf_latency got %0d exp 0", lat); else pass++;
    total++; if (bc !== 0) $display("FAIL ovf_busy got %0d exp 0", bc); else pass++;
    total++; if (dec_s !== 24'h9999) $display("FAIL ovf_dec got %h exp 9999", dec_s); else pass++;
    total++; if (ovf_s !== 1'b1) $display("FAIL ovf_flag got %b exp 1", ovf_s); else pass++;
    total++; if (blank_s !== 6'h0) $display("FAIL ovf_blank got %b exp 0", blank_s); else pass++;
    go(9999, 0, 0, lat, bc);
    total++; if (lat !== 40) $display("FAIL ovf9999_latency got %0d exp 40", lat); else pass++;
    total++; if (dec_s !== 24'h9999) $display("FAIL ovf9999_dec got %h exp 9999", dec_s); else pass++;
    total++; if (ovf_s !== 1'b0) $display("FAIL ovf9999_flag got %b exp 0", ovf_s); else pass++;
  endtask
  task automatic test_wide6;
    int lat, bc;
    sel = 2;
    go(255, 0, 0, lat, bc);
    total++; if (dec_s !== 24'h000255) $display("FAIL wide_dec got %h exp 000255", dec_s); else pass++;
    total++; if (lat !== 18) $display("FAIL wide_latency got %0d exp 18", lat); else pass++;
    total++; if (blank_s !== m_blank(255, 6)) $display("FAIL wide_blank got %b exp %b", blank_s, m_blank(255, 6)); else pass++;
  endtask
  initial begin
    test_reset();
    test_max();
    test_zero();
    test_random(0, 20, 4095);
    test_ignore_st();
    test_abort();
    test_overflow();
    test_random(1, 15, 16383);
    test_wide6();
    test_random(2, 8, 255);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/bin_to_dec_seq.md
# bin_to_dec_seq

Parametrised sequential binary-to-BCD converter, successor to the fixed 12-bit / 4-digit converter in the ADC display path. It converts an unsigned BIN_W-bit sample into DIGITS packed BCD digits by repeated subtraction of decimal weights, with a start/busy/ok handshake. It adds overflow saturation and, optionally, leading-zero blanking for the seven-segment driver. It sits between the ADC sample register and the display multiplexer.

## Interface
- BIN_W, 12: input binary width, 4..20.
- DIGITS, 4: BCD digits produced, 1..6.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- st  in  1  start request; sampled only while busy=0.
- BIN  in  BIN_W  value to convert; sampled on the accepting edge only.
- DEC  out  4*DIGITS  result, digit k at [4k+3:4k]; digit DIGITS-1 is most significant.
- busy  out  1  conversion in progress.
- ok  out  1  one-cycle pulse: DEC/ovf/blank updated.
- ovf  out  1  last accepted BIN ≥ 10^DIGITS.
- blank  out  DIGITS  bit k=1: digit k is a leading zero (see Configuration).

## Operation
- States: IDLE, CONV. Internal: rest (BIN_W bits), ptr (digit index), per-digit counters.
- IDLE with st=1: if BIN ≥ 10^DIGITS, stay IDLE; at the same edge load DEC with all digits 9, set ovf=1, pulse ok. Otherwise load rest=BIN, ptr=DIGITS-1, clear digit counters, go CONV.
- CONV, one action per cycle, weight W=10^ptr:
  - rest ≥ W: rest -= W; digit[ptr]++.
  - rest < W, ptr>0: ptr--.
  - rest < W, ptr=0: load DEC from counters, ovf=0, update blank, pulse ok, go IDLE.
- Weights are constants computed at elaboration, compared at width max(BIN_W, weight width)+1. A weight that does not fit in BIN_W bits yields digit 0 without wrap.
- Digit counters never exceed 9 (guaranteed by the overflow pre-check).
- st during CONV is ignored. BIN changes after acceptance do not affect the result.
- DEC, ovf, blank hold their values between ok pulses.

## Timing
- Reset: IDLE, busy=0, ok=0, ovf=0, DEC=0, blank=0, rest=0, ptr=0.
- busy=1 from the edge that accepts st until the edge that asserts ok. busy=0 in the ok cycle.
- Normal latency: ok rises L = DIGITS + Σdigits edges after the accepting edge. Worst case for 4 digits is 4+4+0+9+5=22 (BIN=4095).
- Overflow latency: ok rises at the accepting edge itself, with busy staying 0.
- Back-to-back: st=1 during the ok cycle is accepted, since busy=0.
- rst_n low mid-conversion: immediate return to reset values. No ok is issued for the aborted conversion.

## Configuration
- BIN2DEC_LZB_EN defined: on each ok, blank[k]=1 for every digit k above the most significant non-zero digit. Digit 0 is never blanked. On overflow, blank=0.
- BIN2DEC_LZB_EN undefined: blank is held at 0. No blanking logic is synthesised. All other behaviour is identical.

## Test plan
- Defaults, BIN=4095, st pulse: busy high 22 cycles; ok 22 edges after accept; DEC=16'h4095, ovf=0.
- BIN=0: ok after 4 edges; DEC=16'h0000. With LZB_EN, blank=4'b1110.
- BIN_W=14, DIGITS=4, BIN=10000: ok at the accepting edge; DEC=16'h9999, ovf=1, busy stays 0. Then BIN=9999: DEC=16'h9999, ovf=0, latency 40.
- BIN=1234; during CONV pulse st with BIN=7: ignored, DEC=16'h1234. A st asserted in the ok cycle with BIN=7 yields DEC=16'h0007; with LZB_EN, blank=4'b1110.
- Pull rst_n low at cycle 5 of the BIN=4095 conversion: all outputs return to 0 asynchronously. No ok. A new conversion then completes normally.
- BIN_W=8, DIGITS=6, BIN=255: DEC=24'h000255, latency 18.
